// File: rtl/i2c_pkg.sv
// Shared definitions for the multi-byte I2C master.
//   state_e : FSM state codes, also exported on the state_out debug port
//   Q0..Q3  : quarter-phase indices within one bit time
//   ADDR_W  : slave address width
//   BYTE_W  : data byte width
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_WR_BYTE  = 4'd4,
    ST_WR_ACK   = 4'd5,
    ST_RD_BYTE  = 4'd6,
    ST_RD_ACK   = 4'd7,
    ST_STOP     = 4'd8,
    ST_DONE     = 4'd9
  } state_e;

endpackage

// File: rtl/i2c_bit_timer.sv
// Bit-time generator: a CLK_DIV divider feeding a 2-bit quarter counter.
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset
//   restart_i  : hold/return the timer to the start of Q0
//   quarter_o  : current quarter phase (Q0..Q3)
//   q_end_o    : last cycle of the current quarter
//   bit_end_o  : last cycle of Q3 (last cycle of the bit)
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       restart_i,
  output logic [1:0] quarter_o,
  output logic       q_end_o,
  output logic       bit_end_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       quarter_q, quarter_d;

  always_comb begin
    q_end_o   = (div_q == DIV_LAST);
    bit_end_o = q_end_o && (quarter_q == Q3);
    div_d     = div_q;
    quarter_d = quarter_q;
    if (restart_i) begin
      div_d     = '0;
      quarter_d = Q0;
    end else if (q_end_o) begin
      div_d     = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q     <= '0;
      quarter_q <= Q0;
    end else begin
      div_q     <= div_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter_o = quarter_q;

endmodule

// File: rtl/i2c_master_multi.sv
// Command-driven 7-bit-address I2C master for multi-byte write/read and
// address-only probes.
//   i2c_clk    : system clock
//   reset      : synchronous active-high reset (no STOP is generated)
//   start      : command request, accepted only in IDLE
//   rw         : 0 = write, 1 = read
//   slave_addr : target address
//   byte_count : data bytes (0 = probe), clamped to MAX_BYTES
//   wr_data    : write bytes, byte k at [8k+7:8k], byte 0 sent first
//   rd_data    : read bytes, same packing, unread bytes are 0
//   busy       : transaction in progress
//   done       : one-cycle end-of-transaction pulse
//   ack_error  : slave NACKed address or a write byte
//   state_out  : FSM state code (debug)
//   scl        : bus clock, push-pull, idle high
//   sda_line   : open-drain data line (drives 0 or Z)
module i2c_master_multi
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                        i2c_clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        rw,
  input  logic [ADDR_W-1:0]           slave_addr,
  input  logic [CNT_W-1:0]            byte_count,
  input  logic [BYTE_W*MAX_BYTES-1:0] wr_data,
  output logic [BYTE_W*MAX_BYTES-1:0] rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        ack_error,
  output logic [3:0]                  state_out,
  output logic                        scl,
  inout  wire                         sda_line
);

  state_e                      state_q, state_d;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]            byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [BYTE_W-1:0]           shift_q, shift_d;
  logic                        rw_q, rw_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [BYTE_W*MAX_BYTES-1:0] wr_data_q, wr_data_d;
  logic [BYTE_W*MAX_BYTES-1:0] rd_data_q, rd_data_d;
  logic                        ack_error_q, ack_error_d;
  logic                        sda_s_q, sda_s_d;

  logic [1:0]       quarter;
  logic             q_end, bit_end, sample;
  logic             sda_low, sda_in;
  logic [CNT_W-1:0] next_idx;
  logic             last_byte;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_i     (i2c_clk),
    .reset_i   (reset),
    .restart_i ((state_q == ST_IDLE) || (state_q == ST_DONE)),
    .quarter_o (quarter),
    .q_end_o   (q_end),
    .bit_end_o (bit_end)
  );

  assign sda_in    = sda_line;
  assign sample    = q_end && (quarter == Q2);
  assign next_idx  = byte_idx_q + 1'b1;
  assign last_byte = (next_idx == count_q);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    count_d     = count_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    rd_data_d   = rd_data_q;
    ack_error_d = ack_error_q;
    sda_s_d     = sda_s_q;

    // The ACK slots reuse sda_s_q; the read byte shifts in at the same point.
    if (sample) begin
      sda_s_d = sda_in;
      if (state_q == ST_RD_BYTE) shift_d = {shift_q[BYTE_W-2:0], sda_in};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_START;
          rw_d        = rw;
          addr_d      = slave_addr;
          count_d     = (byte_count > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : byte_count;
          wr_data_d   = wr_data;
          rd_data_d   = '0;
          ack_error_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_ADDR;
          shift_d   = {addr_q, rw_q};
          bit_cnt_d = '0;
        end
      end
      ST_ADDR, ST_WR_BYTE: begin
        if (bit_end) begin
          shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7)
            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
        end
      end
      ST_ADDR_ACK: begin
        if (bit_end) begin
          byte_idx_d = '0;
          if (sda_s_q) begin
            ack_error_d = 1'b1;
            state_d     = ST_STOP;
          end else if (count_q == '0) begin
            state_d = ST_STOP;
          end else if (rw_q) begin
            state_d = ST_RD_BYTE;
          end else begin
            state_d = ST_WR_BYTE;
            shift_d = wr_data_q[BYTE_W-1:0];
          end
        end
      end
      ST_WR_ACK: begin
        if (bit_end) begin
          if (sda_s_q) begin
            ack_error_d = 1'b1;
            state_d     = ST_STOP;
          end else if (last_byte) begin
            state_d = ST_STOP;
          end else begin
            byte_idx_d = next_idx;
            shift_d    = wr_data_q[BYTE_W*next_idx +: BYTE_W];
            state_d    = ST_WR_BYTE;
          end
        end
      end
      ST_RD_BYTE: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rd_data_d[BYTE_W*byte_idx_q +: BYTE_W] = shift_q;
            state_d = ST_RD_ACK;
          end
        end
      end
      ST_RD_ACK: begin
        if (bit_end) begin
          if (last_byte) begin
            state_d = ST_STOP;
          end else begin
            byte_idx_d = next_idx;
            state_d    = ST_RD_BYTE;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus drive. START keeps SCL high for the whole bit so SDA falls while SCL
  // is high; STOP releases SDA as SCL rises at Q2.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    unique case (state_q)
      ST_START: sda_low = (quarter >= Q2);
      ST_ADDR, ST_WR_BYTE: begin
        scl     = (quarter >= Q2);
        sda_low = ~shift_q[BYTE_W-1];
      end
      ST_ADDR_ACK, ST_WR_ACK, ST_RD_BYTE: scl = (quarter >= Q2);
      ST_RD_ACK: begin
        scl     = (quarter >= Q2);
        sda_low = ~last_byte;
      end
      ST_STOP: begin
        scl     = (quarter >= Q2);
        sda_low = (quarter < Q2);
      end
      default: ;
    endcase
  end

  assign sda_line = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge i2c_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      byte_idx_q  <= '0;
      count_q     <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rd_data_q   <= '0;
      ack_error_q <= 1'b0;
      sda_s_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      rd_data_q   <= rd_data_d;
      ack_error_q <= ack_error_d;
      sda_s_q     <= sda_s_d;
    end
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign ack_error = ack_error_q;
  assign rd_data   = rd_data_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_i2c_master_multi.sv
module tb_i2c_master_multi;

  localparam int CLK_DIV = 4;
  localparam int MAXB    = 4;
  localparam int CW      = 3;
  localparam int LIMIT   = 3000;
  localparam logic [6:0] SLV = 7'b1101001;

  logic        clk = 1'b0;
  logic        reset, start, rw;
  logic [6:0]  slave_addr;
  logic [CW-1:0] byte_count;
  logic [31:0] wr_data, rd_data;
  logic        busy, done, ack_error, scl;
  logic [3:0]  state_out;
  wire         sda;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pullup (sda);

  i2c_master_multi #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAXB)) dut (
    .i2c_clk(clk), .reset(reset), .start(start), .rw(rw),
    .slave_addr(slave_addr), .byte_count(byte_count), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .ack_error(ack_error),
    .state_out(state_out), .scl(scl), .sda_line(sda)
  );

  // ---------------- behavioural bus slave + START/STOP monitor ----------------
  logic        slv_low = 1'b0;
  assign sda = slv_low ? 1'b0 : 1'bz;

  int          slv_nack_at = -1;
  logic [31:0] slv_rsrc = '0;
  logic [7:0]  wr_seen[$];
  logic        acks_seen[$];
  int          starts = 0, stops = 0;
  logic [6:0]  addr_seen = '0;
  logic        rw_seen = 1'b0;

  initial begin
    logic p_scl, p_sda, c_scl, c_sda, sel, srw, rd_end;
    logic [7:0] sh;
    int b, fr;
    p_scl = 1'b1; p_sda = 1'b1; sel = 1'b0; srw = 1'b0; rd_end = 1'b0;
    sh = '0; b = 0; fr = 0;
    forever begin
      @(negedge clk);
      c_scl = scl;
      c_sda = (sda !== 1'b0);
      if (p_scl && c_scl && p_sda && !c_sda) begin
        starts++; b = 0; fr = 0; sel = 1'b0; rd_end = 1'b0; slv_low = 1'b0;
      end else if (c_scl && !p_sda && c_sda) begin
        stops++; b = 0; fr = 0; sel = 1'b0; slv_low = 1'b0;
      end else if (!p_scl && c_scl) begin
        if (b < 8) sh = {sh[6:0], c_sda};
        else if (fr > 0 && sel && srw) begin
          acks_seen.push_back(c_sda);
          if (c_sda) rd_end = 1'b1;
        end
        if (b == 7) begin
          if (fr == 0) begin
            addr_seen = sh[7:1]; rw_seen = sh[0];
            sel = (sh[7:1] == SLV); srw = sh[0];
          end else if (sel && !srw) wr_seen.push_back(sh);
        end
        if (b == 8) begin b = 0; fr++; end else b++;
      end else if (p_scl && !c_scl) begin
        slv_low = 1'b0;
        if (b == 8) begin
          if (fr == 0) slv_low = sel;
          else if (sel && !srw) slv_low = (slv_nack_at != fr - 1);
        end else if (sel && srw && fr >= 1 && fr <= MAXB && !rd_end)
          slv_low = !slv_rsrc[8*(fr-1) + 7 - b];
      end
      p_scl = c_scl; p_sda = c_sda;
    end
  end

  // ---------------- vectors and reference model ----------------
  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [2:0]  cnt;
    logic [31:0] wdata;
    int          nack_at;
    logic [31:0] rsrc;
    logic        exp_err;
    int          exp_bits;
    logic [31:0] exp_rd;
    int          exp_nwr;
    int          exp_nrd;
  } vec_t;

  function automatic vec_t model(input vec_t v);
    int n;
    n = (v.cnt > MAXB) ? MAXB : int'(v.cnt);
    v.exp_err = 1'b0; v.exp_rd = '0; v.exp_nwr = 0; v.exp_nrd = 0;
    if (v.addr != SLV) begin
      v.exp_err = 1'b1; v.exp_bits = 11;
    end else if (n == 0) begin
      v.exp_bits = 11;
    end else if (!v.rw) begin
      if (v.nack_at >= 0 && v.nack_at < n) begin
        v.exp_err = 1'b1; v.exp_nwr = v.nack_at + 1;
        v.exp_bits = 2 + 9 * (2 + v.nack_at);
      end else begin
        v.exp_nwr = n; v.exp_bits = 2 + 9 * (1 + n);
      end
    end else begin
      v.exp_nrd = n; v.exp_bits = 2 + 9 * (1 + n);
      for (int i = 0; i < n; i++) v.exp_rd[8*i +: 8] = v.rsrc[8*i +: 8];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit poke);
    int cyc;
    logic [7:0] wb;
    slv_nack_at = v.nack_at; slv_rsrc = v.rsrc;
    wr_seen.delete(); acks_seen.delete(); starts = 0; stops = 0;
    @(negedge clk);
    rw = v.rw; slave_addr = v.addr; byte_count = v.cnt; wr_data = v.wdata; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rw = ~v.rw; slave_addr = 7'($urandom_range(127));
    byte_count = 3'($urandom_range(7)); wr_data = $urandom;
    cyc = 0;
    chk("busy_after_accept", 64'(busy), 64'(1));
    while (!done && cyc < LIMIT) begin
      if (poke && cyc == 100) start = 1'b1;
      if (poke && cyc == 101) start = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'(1));
    chk("latency_cycles", 64'(cyc), 64'(v.exp_bits * 4 * CLK_DIV));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("ack_error", 64'(ack_error), 64'(v.exp_err));
    chk("rd_data", 64'(rd_data), 64'(v.exp_rd));
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("state_idle_after", 64'(state_out), 64'(0));
    chk("bus_starts", 64'(starts), 64'(1));
    chk("bus_stops", 64'(stops), 64'(1));
    chk("addr_on_bus", 64'({addr_seen, rw_seen}), 64'({v.addr, v.rw}));
    chk("wr_bytes_count", 64'(wr_seen.size()), 64'(v.exp_nwr));
    for (int i = 0; i < v.exp_nwr && i < wr_seen.size(); i++) begin
      wb = v.wdata[8*i +: 8];
      chk("wr_byte", 64'(wr_seen[i]), 64'(wb));
    end
    chk("rd_ack_count", 64'(acks_seen.size()), 64'(v.exp_nrd));
    for (int i = 0; i < v.exp_nrd && i < acks_seen.size(); i++)
      chk("rd_master_ack", 64'(acks_seen[i]), 64'(i == v.exp_nrd - 1));
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; slave_addr = '0; byte_count = '0; wr_data = '0;

    //           rw    addr   cnt   wdata         nack rsrc          err  bits rd            nwr nrd
    tbl[0] = '{1'b0, SLV,   3'd1, 32'h000000AA, -1, 32'h0,        1'b0, 20, 32'h0,        1, 0};
    tbl[1] = '{1'b0, SLV,   3'd2, 32'h000055AA, -1, 32'h0,        1'b0, 29, 32'h0,        2, 0};
    tbl[2] = '{1'b0, 7'h01, 3'd1, 32'h000000AA, -1, 32'h0,        1'b1, 11, 32'h0,        0, 0};
    tbl[3] = '{1'b1, SLV,   3'd3, 32'h0,        -1, 32'h00563412, 1'b0, 38, 32'h00563412, 0, 3};
    tbl[4] = '{1'b0, SLV,   3'd0, 32'h000000AA, -1, 32'h0,        1'b0, 11, 32'h0,        0, 0};
    tbl[5] = '{1'b0, SLV,   3'd7, 32'h44332211, -1, 32'h0,        1'b0, 47, 32'h0,        4, 0};
    tbl[6] = '{1'b0, SLV,   3'd3, 32'h00CCBBAA,  1, 32'h0,        1'b1, 29, 32'h0,        2, 0};
    tbl[7] = '{1'b1, SLV,   3'd7, 32'h0,        -1, 32'hDEADBEEF, 1'b0, 47, 32'hDEADBEEF, 0, 4};
    tbl[8] = '{1'b1, 7'h01, 3'd2, 32'h0,        -1, 32'h0000FFFF, 1'b1, 11, 32'h0,        0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", 64'(scl), 64'(1));
    chk("rst_sda", 64'(sda), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ack_error", 64'(ack_error), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_state", 64'(state_out), 64'(0));
    @(negedge clk); reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], 1'b0);

    // start pulsed mid-transaction with scrambled inputs must be ignored
    run_vec(tbl[1], 1'b1);

    // reset asserted in the middle of the address byte
    @(negedge clk);
    rw = 1'b0; slave_addr = 7'h00; byte_count = 3'd2; wr_data = 32'h0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4 * CLK_DIV + 40) @(posedge clk);
    #1;
    chk("mid_state_addr", 64'(state_out), 64'(2));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_scl", 64'(scl), 64'(1));
    chk("midrst_sda", 64'(sda), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_state", 64'(state_out), 64'(0));
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);

    for (int k = 0; k < 16; k++) begin
      rv.rw      = 1'($urandom_range(1));
      rv.addr    = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : SLV;
      rv.cnt     = 3'($urandom_range(7));
      rv.wdata   = $urandom;
      rv.rsrc    = $urandom;
      rv.nack_at = ($urandom_range(2) == 0) ? int'($urandom_range(3)) : -1;
      rv         = model(rv);
      run_vec(rv, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
